// File: rtl/unidade_controle.sv
// unidade_controle -- multi-cycle control unit (FETCH, DECODE, EXEC, MEM, WB).
// Ports:
//   clock, reset_n       : clock and synchronous active-low reset
//   instr_in/instr_valid : instruction word and its valid flag; instr_ready
//                          is the acceptance handshake (high only in FETCH)
//   zero_flag, mem_ready : ALU zero flag and data-memory completion
//   ula_op, alu_src_a/b  : ALU operation and operand selects, held from
//                          DECODE to the final state of each instruction
//   reg_dst, reg_write, mem_to_reg : register-file write-back control
//   mem_read, mem_write  : data-memory requests held until mem_ready
//   pc_write, pc_src     : PC update strobe and next-PC source
//   illegal              : one-cycle pulse on an unsupported instruction
//   busy                 : high in every state except FETCH
module unidade_controle (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        zero_flag,
  input  logic        mem_ready,
  output logic [4:0]  ula_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        illegal,
  output logic        busy
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [2:0] {
    K_ILLEGAL, K_ALU_R, K_JR, K_ALU_I, K_BRANCH, K_LW, K_SW, K_J
  } kind_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;

  kind_t       kind;
  logic [4:0]  dec_op;
  logic        dec_a;
  logic [1:0]  dec_b;

  // Register and immediate fields go to the datapath, not to this control unit.
  logic [19:0] ir_fields_unused;
  assign ir_fields_unused = ir_q[25:6];

  // Instruction classification; the result is a pure function of IR, so the
  // ALU op and operand selects stay stable for the whole instruction.
  always_comb begin
    kind   = K_ILLEGAL;
    dec_op = '0;
    dec_a  = 1'b0;
    dec_b  = 2'b00;
    case (ir_q[31:26])
      6'h00: begin
        kind = K_ALU_R;
        case (ir_q[5:0])
          6'h24: dec_op = 5'b00000;
          6'h25: dec_op = 5'b00001;
          6'h20: dec_op = 5'b00010;
          6'h26: dec_op = 5'b00011;
          6'h27: dec_op = 5'b00100;
          6'h2A: dec_op = 5'b00101;
          6'h22: dec_op = 5'b00110;
          6'h2B: dec_op = 5'b00111;
          6'h00: begin dec_op = 5'b01000; dec_a = 1'b1; dec_b = 2'b10; end
          6'h02: begin dec_op = 5'b01001; dec_a = 1'b1; dec_b = 2'b10; end
          6'h03: begin dec_op = 5'b01010; dec_a = 1'b1; dec_b = 2'b10; end
          6'h04: begin dec_op = 5'b01011; dec_a = 1'b1; end
          6'h06: begin dec_op = 5'b01100; dec_a = 1'b1; end
          6'h07: begin dec_op = 5'b01101; dec_a = 1'b1; end
          6'h08: begin dec_op = 5'b01110; kind = K_JR; end
          default: kind = K_ILLEGAL;
        endcase
      end
      6'h08: begin kind = K_ALU_I;  dec_op = 5'b10000; dec_b = 2'b01; end
      6'h0C: begin kind = K_ALU_I;  dec_op = 5'b10001; dec_b = 2'b01; end
      6'h0D: begin kind = K_ALU_I;  dec_op = 5'b10010; dec_b = 2'b01; end
      6'h0E: begin kind = K_ALU_I;  dec_op = 5'b10011; dec_b = 2'b01; end
      6'h04: begin kind = K_BRANCH; dec_op = 5'b10100; end
      6'h05: begin kind = K_BRANCH; dec_op = 5'b10101; end
      6'h0A: begin kind = K_ALU_I;  dec_op = 5'b10111; dec_b = 2'b01; end
      6'h0B: begin kind = K_ALU_I;  dec_op = 5'b11000; dec_b = 2'b01; end
      6'h0F: begin kind = K_ALU_I;  dec_op = 5'b11001; dec_b = 2'b11; end
      6'h23: begin kind = K_LW;     dec_op = 5'b11010; dec_b = 2'b01; end
      6'h2B: begin kind = K_SW;     dec_op = 5'b11011; dec_b = 2'b01; end
      6'h02: begin kind = K_J;      dec_op = 5'b01111; end
      default: kind = K_ILLEGAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    instr_ready = 1'b0;
    ula_op      = '0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    reg_dst     = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    illegal     = 1'b0;
    busy        = (state_q != FETCH);

    if (state_q != FETCH) begin
      ula_op    = dec_op;
      alu_src_a = dec_a;
      alu_src_b = dec_b;
    end

    case (state_q)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_d     = instr_in;
          pc_write = 1'b1;
          pc_src   = 2'b00;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        case (kind)
          K_ILLEGAL: begin illegal = 1'b1; state_d = FETCH; end
          K_J: begin pc_write = 1'b1; pc_src = 2'b10; state_d = FETCH; end
          default: state_d = EXEC;
        endcase
      end
      EXEC: begin
        case (kind)
          K_ALU_R, K_ALU_I: state_d = WB;
          K_LW, K_SW:       state_d = MEM;
          K_BRANCH: begin
            pc_write = ~zero_flag;
            pc_src   = 2'b01;
            state_d  = FETCH;
          end
          K_JR: begin pc_write = 1'b1; pc_src = 2'b11; state_d = FETCH; end
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        if (kind == K_LW) begin
          mem_read = 1'b1;
          if (mem_ready) state_d = WB;
        end else if (kind == K_SW) begin
          mem_write = 1'b1;
          if (mem_ready) state_d = FETCH;
        end else begin
          state_d = FETCH;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = (kind == K_ALU_R);
        mem_to_reg = (kind == K_LW);
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle -- directed scenarios plus randomized instruction
// streams for unidade_controle, checked against a latency/strobe-table model.
module tb_unidade_controle;

  logic        clock, reset_n;
  logic [31:0] instr_in;
  logic        instr_valid, instr_ready, zero_flag, mem_ready;
  logic [4:0]  ula_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        reg_dst, reg_write, mem_to_reg, mem_read, mem_write, pc_write;
  logic [1:0]  pc_src;
  logic        illegal, busy;

  int errors = 0;
  int checks = 0;

  unidade_controle dut (
    .clock(clock), .reset_n(reset_n), .instr_in(instr_in),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .ula_op(ula_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_dst(reg_dst),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
    .mem_write(mem_write), .pc_write(pc_write), .pc_src(pc_src),
    .illegal(illegal), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [6:0]  strobes;
  logic [18:0] all_out;
  assign strobes = {instr_ready, busy, pc_write, reg_write, mem_read, mem_write, illegal};
  assign all_out = {instr_ready, busy, pc_write, reg_write, mem_read, mem_write, illegal,
                    ula_op, alu_src_a, alu_src_b, reg_dst, mem_to_reg, pc_src};

  // Reference tables: R-type funct at index i has ALU code i.
  logic [5:0] r_funct [15] = '{6'h24, 6'h25, 6'h20, 6'h26, 6'h27, 6'h2A, 6'h22, 6'h2B,
                               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
  logic [5:0] i_opc [11] = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h05, 6'h0A, 6'h0B,
                             6'h0F, 6'h23, 6'h2B};
  logic [4:0] i_op  [11] = '{5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd23, 5'd24,
                             5'd25, 5'd26, 5'd27};

  localparam int K_ILL = 0, K_R = 1, K_JR = 2, K_I = 3, K_BR = 4, K_LW = 5, K_SW = 6, K_J = 7;

  function automatic void model(input logic [31:0] w, output int kind,
                                output logic [4:0] op, output logic a, output logic [1:0] b);
    logic [5:0] opc, fn;
    opc = w[31:26];
    fn  = w[5:0];
    kind = K_ILL; op = '0; a = 1'b0; b = 2'b00;
    if (opc == 6'h00) begin
      for (int i = 0; i < 15; i++)
        if (r_funct[i] == fn) begin
          op   = i[4:0];
          kind = (i == 14) ? K_JR : K_R;
          a    = (i >= 8 && i <= 13);
          b    = (i >= 8 && i <= 10) ? 2'b10 : 2'b00;
        end
    end else if (opc == 6'h02) begin
      kind = K_J; op = 5'd15;
    end else begin
      for (int i = 0; i < 11; i++)
        if (i_opc[i] == opc) begin
          op   = i_op[i];
          b    = (opc == 6'h04 || opc == 6'h05) ? 2'b00 : (opc == 6'h0F) ? 2'b11 : 2'b01;
          kind = (opc == 6'h04 || opc == 6'h05) ? K_BR :
                 (opc == 6'h23) ? K_LW : (opc == 6'h2B) ? K_SW : K_I;
        end
    end
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; instr_valid = 1'b0;
    zero_flag = 1'($urandom_range(0, 1)); mem_ready = 1'($urandom_range(0, 1));
    instr_in = $urandom;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clock);
      checks++;
      if (all_out !== 19'h40000) begin
        errors++;
        $display("FAIL reset_state cycle=%0d got=%b exp=%b", i, all_out, 19'h40000);
      end
    end
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_add();
    int rw_cnt = 0;
    instr_in = 32'h012A4020; instr_valid = 1'b1; zero_flag = 1'b0; mem_ready = 1'b0;
    @(negedge clock);
    checks++;
    if ({instr_ready, pc_write, pc_src} !== 4'b1100) begin
      errors++;
      $display("FAIL add_accept got=%b exp=1100", {instr_ready, pc_write, pc_src});
    end
    next_cycle();
    instr_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      rw_cnt += int'(reg_write);
      if (k <= 3) begin
        checks++;
        if (ula_op !== 5'b00010 || busy !== 1'b1) begin
          errors++;
          $display("FAIL add_op k=%0d got=%b/%b exp=00010/1", k, ula_op, busy);
        end
      end
      if (k == 3) begin
        checks++;
        if ({reg_write, reg_dst, mem_to_reg} !== 3'b110) begin
          errors++;
          $display("FAIL add_wb got=%b exp=110", {reg_write, reg_dst, mem_to_reg});
        end
      end
      if (k == 4) begin
        checks++;
        if ({instr_ready, busy} !== 2'b10) begin
          errors++;
          $display("FAIL add_return got=%b exp=10", {instr_ready, busy});
        end
      end
      next_cycle();
    end
    checks++;
    if (rw_cnt != 1) begin
      errors++;
      $display("FAIL add_rw_count got=%0d exp=1", rw_cnt);
    end
  endtask

  task automatic test_beq(input logic z);
    instr_in = 32'h11090003; instr_valid = 1'b1; zero_flag = z;
    next_cycle();
    instr_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      if (k == 1) begin
        checks++;
        if (ula_op !== 5'b10100 || alu_src_b !== 2'b00) begin
          errors++;
          $display("FAIL beq_decode got=%b/%b exp=10100/00", ula_op, alu_src_b);
        end
      end
      if (k == 2) begin
        checks++;
        if (pc_write !== ~z) begin
          errors++;
          $display("FAIL beq_pcw zero=%b got=%b exp=%b", z, pc_write, ~z);
        end
        if (!z) begin
          checks++;
          if (pc_src !== 2'b01) begin
            errors++;
            $display("FAIL beq_pcsrc got=%b exp=01", pc_src);
          end
        end
      end
      if (k == 3) begin
        checks++;
        if (instr_ready !== 1'b1 || pc_write !== 1'b0) begin
          errors++;
          $display("FAIL beq_return got=%b%b exp=10", instr_ready, pc_write);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_lw_wait();
    int mr_cnt = 0, rw_cnt = 0;
    instr_in = 32'h8D090004; instr_valid = 1'b1; mem_ready = 1'b0;
    next_cycle();
    instr_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      mem_ready = (k == 6);
      @(negedge clock);
      mr_cnt += int'(mem_read);
      rw_cnt += int'(reg_write);
      if (k == 7) begin
        checks++;
        if ({reg_write, mem_to_reg, reg_dst} !== 3'b110) begin
          errors++;
          $display("FAIL lw_wb got=%b exp=110", {reg_write, mem_to_reg, reg_dst});
        end
      end
      if (k == 8) begin
        checks++;
        if ({instr_ready, busy} !== 2'b10) begin
          errors++;
          $display("FAIL lw_return got=%b exp=10", {instr_ready, busy});
        end
      end
      next_cycle();
    end
    checks++;
    if (mr_cnt != 4 || rw_cnt != 1) begin
      errors++;
      $display("FAIL lw_counts mem_read=%0d reg_write=%0d exp=4,1", mr_cnt, rw_cnt);
    end
  endtask

  task automatic test_illegal();
    instr_in = 32'hFC000000; instr_valid = 1'b1;
    next_cycle();
    instr_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (strobes !== 7'b0100001) begin
      errors++;
      $display("FAIL illegal_decode got=%b exp=0100001", strobes);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (strobes !== 7'b1000000) begin
      errors++;
      $display("FAIL illegal_return got=%b exp=1000000", strobes);
    end
    next_cycle();
  endtask

  task automatic test_reset_mem();
    int strobe_cnt = 0;
    instr_in = 32'hAD090004; instr_valid = 1'b1; mem_ready = 1'b0;
    next_cycle();
    instr_valid = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clock);
    checks++;
    if (mem_write !== 1'b1) begin
      errors++;
      $display("FAIL sw_mem_write got=%b exp=1", mem_write);
    end
    next_cycle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (all_out !== 19'h40000) begin
      errors++;
      $display("FAIL sw_reset_state got=%b exp=%b", all_out, 19'h40000);
    end
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clock);
      strobe_cnt += int'(reg_write) + int'(mem_write) + int'(mem_read) + int'(pc_write);
    end
    checks++;
    if (strobe_cnt != 0) begin
      errors++;
      $display("FAIL sw_aborted_strobes got=%0d exp=0", strobe_cnt);
    end
    next_cycle();
  endtask

  task automatic test_jump();
    int bad = 0;
    instr_in = 32'h08000010; instr_valid = 1'b1;
    next_cycle();
    instr_valid = 1'b0;
    @(negedge clock);
    bad += int'(reg_write) + int'(mem_write);
    checks++;
    if ({pc_write, pc_src, ula_op} !== 8'b1_10_01111) begin
      errors++;
      $display("FAIL jump_decode got=%b exp=11001111", {pc_write, pc_src, ula_op});
    end
    next_cycle();
    @(negedge clock);
    bad += int'(reg_write) + int'(mem_write);
    checks++;
    if (instr_ready !== 1'b1 || bad != 0) begin
      errors++;
      $display("FAIL jump_return ready=%b bad_strobes=%0d exp=1,0", instr_ready, bad);
    end
    next_cycle();
  endtask

  task automatic test_random(input int count);
    for (int t = 0; t < count; t++) begin
      logic [31:0] w;
      int kind, n, len, sel;
      logic [4:0] op;
      logic a, z;
      logic [1:0] b, esrc;
      logic [6:0] exp_s;
      sel = $urandom_range(0, 9);
      w = $urandom;
      if (sel < 4)       w = {6'h00, w[25:6], r_funct[$urandom_range(0, 14)]};
      else if (sel < 8)  w = {i_opc[$urandom_range(0, 10)], w[25:0]};
      else if (sel == 8) w = {6'h02, w[25:0]};
      model(w, kind, op, a, b);
      z = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 4);
      case (kind)
        K_R, K_I:     len = 3;
        K_BR, K_JR:   len = 2;
        K_SW:         len = 2 + n;
        K_LW:         len = 3 + n;
        default:      len = 1;
      endcase
      zero_flag = z;
      for (int k = 0; k <= len + 1; k++) begin
        instr_valid = (k == 0) ? 1'b1 : (k <= len) ? 1'($urandom_range(0, 1)) : 1'b0;
        instr_in    = (k == 0) ? w : $urandom;
        mem_ready   = (k < 3) ? 1'($urandom_range(0, 1)) : (k >= 2 + n);
        @(negedge clock);
        exp_s = '0;
        esrc  = 2'b00;
        exp_s[6] = (k == 0 || k == len + 1);
        exp_s[5] = (k >= 1 && k <= len);
        if (k == 0) exp_s[4] = 1'b1;
        if (k == 1 && kind == K_J)  begin exp_s[4] = 1'b1; esrc = 2'b10; end
        if (k == 1 && kind == K_ILL) exp_s[0] = 1'b1;
        if (k == 2 && kind == K_BR) begin exp_s[4] = ~z; esrc = 2'b01; end
        if (k == 2 && kind == K_JR) begin exp_s[4] = 1'b1; esrc = 2'b11; end
        if (k == 3 && (kind == K_R || kind == K_I)) exp_s[3] = 1'b1;
        if (kind == K_LW && k >= 3 && k <= 2 + n) exp_s[2] = 1'b1;
        if (kind == K_LW && k == 3 + n) exp_s[3] = 1'b1;
        if (kind == K_SW && k >= 3 && k <= 2 + n) exp_s[1] = 1'b1;
        checks++;
        if (strobes !== exp_s) begin
          errors++;
          $display("FAIL rnd_strobes instr=%h k=%0d got=%b exp=%b", w, k, strobes, exp_s);
        end
        if (exp_s[4]) begin
          checks++;
          if (pc_src !== esrc) begin
            errors++;
            $display("FAIL rnd_pc_src instr=%h k=%0d got=%b exp=%b", w, k, pc_src, esrc);
          end
        end
        if (exp_s[3]) begin
          checks++;
          if ({reg_dst, mem_to_reg} !== {kind == K_R, kind == K_LW}) begin
            errors++;
            $display("FAIL rnd_wb instr=%h got=%b%b", w, reg_dst, mem_to_reg);
          end
        end
        if (k >= 1 && k <= len && kind != K_ILL) begin
          checks++;
          if (ula_op !== op) begin
            errors++;
            $display("FAIL rnd_ula_op instr=%h k=%0d got=%b exp=%b", w, k, ula_op, op);
          end
          if (kind != K_J) begin
            checks++;
            if ({alu_src_a, alu_src_b} !== {a, b}) begin
              errors++;
              $display("FAIL rnd_src instr=%h k=%0d got=%b exp=%b", w, k,
                       {alu_src_a, alu_src_b}, {a, b});
            end
          end
        end
        next_cycle();
      end
      if (busy) begin
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; instr_valid = 1'b0; instr_in = '0; zero_flag = 1'b0; mem_ready = 1'b0;
    next_cycle();
    test_reset();
    test_add();
    test_beq(1'b0);
    test_beq(1'b1);
    test_lw_wait();
    test_illegal();
    test_reset_mem();
    test_jump();
    test_random(300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The module SHALL have these ports, clock and reset first:
- clock  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  synchronous, active-low reset
- instr_in  in  32  instruction word from instruction memory
- instr_valid  in  1  instr_in holds a valid word
- instr_ready  out  1  block can accept an instruction
- zero_flag  in  1  Zero_flag from the ALU
- mem_ready  in  1  data memory has completed the access
- ula_op  out  5  OP code driven to the ALU
- alu_src_a  out  1  ALU In1 select: 0 = rs, 1 = rt
- alu_src_b  out  2  ALU In2 select: 00 = rt, 01 = imm16 zero-extended, 10 = shamt, 11 = imm16 raw (LUI)
- reg_dst  out  1  write-back register: 0 = rt, 1 = rd
- reg_write  out  1  register-file write strobe
- mem_to_reg  out  1  write-back source: 0 = ALU result, 1 = memory data
- mem_read  out  1  data memory read request
- mem_write  out  1  data memory write request
- pc_write  out  1  PC update strobe
- pc_src  out  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = rs (JR)
- illegal  out  1  one-cycle pulse on an unsupported instruction
- busy  out  1  high in every state except FETCH

Function
REQ-002 The block SHALL be a multi-cycle FSM with the states FETCH, DECODE, EXEC, MEM and WB, and SHALL hold an internal 32-bit instruction register (IR).
REQ-003 FETCH SHALL assert instr_ready; when instr_valid is also high, the block SHALL load IR, pulse pc_write with pc_src = 00, and go to DECODE.
REQ-004 DECODE SHALL last one cycle and SHALL map IR to ula_op as follows:
- R-type (opcode 0x00), by funct: 0x24 AND 00000, 0x25 OR 00001, 0x20 ADD 00010, 0x26 XOR 00011, 0x27 NOR 00100, 0x2A SLT 00101, 0x22 SUB 00110, 0x2B SLTU 00111, 0x00 SLL 01000, 0x02 SRL 01001, 0x03 SRA 01010, 0x04 SLLV 01011, 0x06 SRLV 01100, 0x07 SRAV 01101, 0x08 JR 01110.
- I-type, by opcode: 0x08 ADDI 10000, 0x0C ANDI 10001, 0x0D ORI 10010, 0x0E XORI 10011, 0x04 BEQ 10100, 0x05 BNE 10101, 0x0A SLTI 10111, 0x0B SLTIU 11000, 0x0F LUI 11001, 0x23 LW 11010, 0x2B SW 11011.
REQ-005 For an opcode 0x02 (J) in DECODE, the block SHALL pulse pc_write with pc_src = 10, drive ula_op = 01111, and return to FETCH.
REQ-006 For any other opcode or funct in DECODE, the block SHALL pulse illegal for one cycle, assert no strobes, and return to FETCH.
REQ-007 Operand selects SHALL be: SLL/SRL/SRA use alu_src_a = 1 and alu_src_b = 10; SLLV/SRLV/SRAV use alu_src_a = 1 and alu_src_b = 00 with the shift amount taken from rs; other R-type use alu_src_a = 0 and alu_src_b = 00; I-type ALU ops, LW and SW use alu_src_b = 01; LUI uses alu_src_b = 11; BEQ/BNE use alu_src_b = 00.
REQ-008 ula_op and the operand selects SHALL be held stable from DECODE through the final state of each instruction.
REQ-009 In EXEC, the next state SHALL be:
- ALU ops: go to WB.
- LW/SW: go to MEM.
- BEQ/BNE: pc_write = ~zero_flag with pc_src = 01, then go to FETCH.
- JR: pulse pc_write with pc_src = 11, then go to FETCH.
REQ-010 MEM SHALL hold mem_read (LW) or mem_write (SW) high until the cycle in which mem_ready = 1; LW SHALL then go to WB and SW to FETCH; there SHALL be no timeout.
REQ-011 WB SHALL pulse reg_write for one cycle, with reg_dst = 1 for R-type and 0 otherwise, and mem_to_reg = 1 only for LW, then go to FETCH.
REQ-012 Latency from instruction accept to return to FETCH SHALL be: R/I ALU ops 3 cycles; branch and JR 2 cycles; J and illegal 1 cycle; SW 2 + n cycles; LW 3 + n cycles, where n is the number of MEM cycles including the mem_ready cycle (n ≥ 1).
REQ-013 reg_write, mem_write and pc_write SHALL never be asserted in the same cycle, and a new instruction SHALL NOT be accepted while busy = 1.

Reset
REQ-014 When reset_n = 0 at a clock edge, the block SHALL enter FETCH, clear IR to 0, and drive all outputs to 0, except instr_ready = 1 from the first cycle after reset.
REQ-015 Reset SHALL take priority over every state, including a pending MEM access; the aborted instruction SHALL produce no further strobes.

Verification
REQ-016 ADD: instr 0x012A4020 accepted -> DECODE, EXEC, WB; ula_op = 00010; reg_write = 1 for exactly one cycle with reg_dst = 1; back in FETCH 3 cycles after accept.
REQ-017 BEQ: instr 0x11090003 with zero_flag = 0 in EXEC -> pc_write = 1 and pc_src = 01 in EXEC; with zero_flag = 1 -> pc_write stays 0.
REQ-018 LW with mem_ready held low 3 cycles: instr 0x8D090004 -> mem_read high for 4 cycles, then one WB cycle with mem_to_reg = 1 and reg_write = 1.
REQ-019 Illegal instruction: instr 0xFC000000 -> illegal pulses once in DECODE, no other strobes, instr_ready = 1 on the next cycle.
REQ-020 Reset during SW in MEM: reset_n = 0 for one edge -> mem_write = 0 and all strobes 0 next cycle, state FETCH, instr_ready = 1.
REQ-021 J: instr 0x08000010 -> pc_write = 1 and pc_src = 10 in DECODE; back in FETCH 1 cycle after accept; reg_write and mem_write never asserted.
